// File: rtl/req_ack_cdc.sv
// Two-phase req/ack toggle CDC moving one WIDTH-bit word at a time.
// The src hold register is the only multi-bit crossing; it is frozen while req != ack.
`timescale 1ns/1ps
module req_ack_cdc #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             src_clk,
    input  logic             src_rst_n,
    input  logic             dst_clk,
    input  logic             dst_rst_n,
    input  logic             src_valid,
    output logic             src_ready,
    input  logic [WIDTH-1:0] src_data,
    output logic             dst_valid,
    input  logic             dst_ready,
    output logic [WIDTH-1:0] dst_data,
    output logic             src_busy
);

    typedef enum logic {S_IDLE, S_WAIT} src_state_e;
    typedef enum logic {D_IDLE, D_VALID} dst_state_e;

    src_state_e             src_state_q, src_state_d;
    logic                   req_tgl_q, req_tgl_d;
    logic [WIDTH-1:0]       hold_q, hold_d;
    logic [SYNC_STAGES-1:0] ack_sync_q, ack_sync_d;
    logic                   src_ready_q, src_ready_d;

    dst_state_e             dst_state_q, dst_state_d;
    logic                   ack_tgl_q, ack_tgl_d;
    logic [WIDTH-1:0]       dst_data_q, dst_data_d;
    logic [SYNC_STAGES-1:0] req_sync_q, req_sync_d;
    logic                   dst_valid_q, dst_valid_d;

    always_comb begin
        src_state_d = src_state_q;
        req_tgl_d   = req_tgl_q;
        hold_d      = hold_q;
        ack_sync_d  = {ack_sync_q[SYNC_STAGES-2:0], ack_tgl_q};
        unique case (src_state_q)
            S_IDLE: begin
                if (src_valid) begin
                    hold_d      = src_data;
                    req_tgl_d   = ~req_tgl_q;
                    src_state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // ack caught up with req: dst has consumed the hold register
                if (ack_sync_q[SYNC_STAGES-1] == req_tgl_q) begin
                    src_state_d = S_IDLE;
                end
            end
        endcase
        src_ready_d = (src_state_d == S_IDLE);
    end

    always_ff @(posedge src_clk or negedge src_rst_n) begin
        if (!src_rst_n) begin
            src_state_q <= S_IDLE;
            req_tgl_q   <= 1'b0;
            hold_q      <= '0;
            ack_sync_q  <= '0;
            src_ready_q <= 1'b1;
        end else begin
            src_state_q <= src_state_d;
            req_tgl_q   <= req_tgl_d;
            hold_q      <= hold_d;
            ack_sync_q  <= ack_sync_d;
            src_ready_q <= src_ready_d;
        end
    end

    always_comb begin
        dst_state_d = dst_state_q;
        ack_tgl_d   = ack_tgl_q;
        dst_data_d  = dst_data_q;
        req_sync_d  = {req_sync_q[SYNC_STAGES-2:0], req_tgl_q};
        unique case (dst_state_q)
            D_IDLE: begin
                // hold_q is stable here since src cannot change it until ack returns
                if (req_sync_q[SYNC_STAGES-1] != ack_tgl_q) begin
                    dst_data_d  = hold_q;
                    dst_state_d = D_VALID;
                end
            end
            D_VALID: begin
                if (dst_ready) begin
                    ack_tgl_d   = ~ack_tgl_q;
                    dst_state_d = D_IDLE;
                end
            end
        endcase
        dst_valid_d = (dst_state_d == D_VALID);
    end

    always_ff @(posedge dst_clk or negedge dst_rst_n) begin
        if (!dst_rst_n) begin
            dst_state_q <= D_IDLE;
            ack_tgl_q   <= 1'b0;
            dst_data_q  <= '0;
            req_sync_q  <= '0;
            dst_valid_q <= 1'b0;
        end else begin
            dst_state_q <= dst_state_d;
            ack_tgl_q   <= ack_tgl_d;
            dst_data_q  <= dst_data_d;
            req_sync_q  <= req_sync_d;
            dst_valid_q <= dst_valid_d;
        end
    end

    assign src_ready = src_ready_q;
    assign src_busy  = ~src_ready_q;
    assign dst_valid = dst_valid_q;
    assign dst_data  = dst_data_q;

endmodule

// File: tb/tb_req_ack_cdc.sv
// Bench for req_ack_cdc: accepted words go into a queue and are
// matched in order against deliveries on the destination side.
`timescale 1ns/1ps
module tb_req_ack_cdc;

    localparam int WIDTH = 8;

    logic             src_clk = 1'b0;
    logic             dst_clk = 1'b0;
    logic             src_rst_n;
    logic             dst_rst_n;
    logic             src_valid;
    logic             src_ready;
    logic [WIDTH-1:0] src_data;
    logic             dst_valid;
    logic             dst_ready;
    logic [WIDTH-1:0] dst_data;
    logic             src_busy;

    real src_half = 5.0;
    real dst_half = 13.5;

    int passed = 0;
    int total = 0;
    int accepted = 0;
    int delivered = 0;
    logic [WIDTH-1:0] exp_q[$];
    bit hold_chk = 1'b0;
    logic [WIDTH-1:0] hold_data = '0;
    bit rnd_done = 1'b0;

    req_ack_cdc #(.WIDTH(WIDTH), .SYNC_STAGES(2)) dut (
        .src_clk(src_clk),
        .src_rst_n(src_rst_n),
        .dst_clk(dst_clk),
        .dst_rst_n(dst_rst_n),
        .src_valid(src_valid),
        .src_ready(src_ready),
        .src_data(src_data),
        .dst_valid(dst_valid),
        .dst_ready(dst_ready),
        .dst_data(dst_data),
        .src_busy(src_busy)
    );

    always #(src_half) src_clk = ~src_clk;

    initial begin
        #1.3;
        forever #(dst_half) dst_clk = ~dst_clk;
    end

    task automatic src_monitor;
        forever begin
            @(negedge src_clk);
            if (src_rst_n) begin
                total++;
                if (src_ready !== ~src_busy)
                    $display("FAIL ready_vs_busy: src_ready=%b src_busy=%b, need inverse", src_ready, src_busy);
                else
                    passed++;
                if (src_valid && src_ready) begin
                    exp_q.push_back(src_data);
                    accepted++;
                end
            end
        end
    endtask

    task automatic dst_monitor;
        logic [WIDTH-1:0] e;
        forever begin
            @(negedge dst_clk);
            if (dst_rst_n) begin
                if (hold_chk) begin
                    total++;
                    if (dst_valid !== 1'b1 || dst_data !== hold_data)
                        $display("FAIL stall_hold: valid=%b data=%h, need valid=1 data=%h", dst_valid, dst_data, hold_data);
                    else
                        passed++;
                end
                if (dst_valid && dst_ready) begin
                    total++;
                    delivered++;
                    if (exp_q.size() == 0) begin
                        $display("FAIL sb_extra: delivered %h with nothing outstanding", dst_data);
                    end else begin
                        e = exp_q.pop_front();
                        if (dst_data !== e)
                            $display("FAIL sb_data: got %h, need %h", dst_data, e);
                        else
                            passed++;
                    end
                end
                hold_chk  = dst_valid && !dst_ready;
                hold_data = dst_data;
            end else begin
                hold_chk = 1'b0;
            end
        end
    endtask

    task automatic drive_dst_ready(input logic v);
        @(posedge dst_clk);
        #1 dst_ready = v;
    endtask

    // Returns at the accept edge; src_valid drops just after it.
    task automatic src_offer(input logic [WIDTH-1:0] d, output bit ok);
        ok = 1'b0;
        @(posedge src_clk);
        #1;
        src_valid = 1'b1;
        src_data  = d;
        for (int i = 0; i < 400; i++) begin
            @(negedge src_clk);
            if (src_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge src_clk);
        fork
            begin
                #1 src_valid = 1'b0;
            end
        join_none
    endtask

    task automatic test_reset;
        #20;
        total++;
        if (src_ready !== 1'b1) $display("FAIL reset_src_ready: got %b, need 1", src_ready);
        else passed++;
        total++;
        if (src_busy !== 1'b0) $display("FAIL reset_src_busy: got %b, need 0", src_busy);
        else passed++;
        total++;
        if (dst_valid !== 1'b0) $display("FAIL reset_dst_valid: got %b, need 0", dst_valid);
        else passed++;
        total++;
        if (dst_data !== 8'h00) $display("FAIL reset_dst_data: got %h, need 00", dst_data);
        else passed++;
        @(posedge dst_clk);
        #1 dst_rst_n = 1'b1;
        @(posedge src_clk);
        #1 src_rst_n = 1'b1;
        repeat (3) @(posedge src_clk);
    endtask

    task automatic test_single;
        bit ok;
        int n;
        int m;
        drive_dst_ready(1'b1);
        src_offer(8'hA5, ok);
        total++;
        if (!ok) $display("FAIL single_accept: got no accept, need accept");
        else passed++;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge dst_clk);
            n++;
            #1;
            if (dst_valid) break;
        end
        total++;
        if (n < 3 || n > 4) $display("FAIL single_dst_latency: got %0d edges, need 3..4", n);
        else passed++;
        total++;
        if (dst_data !== 8'hA5) $display("FAIL single_data: got %h, need a5", dst_data);
        else passed++;
        @(posedge dst_clk);
        m = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge src_clk);
            m++;
            #1;
            if (src_ready) break;
        end
        total++;
        if (m < 3 || m > 4) $display("FAIL single_src_latency: got %0d edges, need 3..4", m);
        else passed++;
        repeat (3) @(posedge src_clk);
    endtask

    task automatic test_backpressure;
        bit ok;
        int del0;
        del0 = delivered;
        drive_dst_ready(1'b0);
        src_offer(8'h3C, ok);
        total++;
        if (!ok) $display("FAIL bp_accept: got no accept, need accept");
        else passed++;
        for (int i = 0; i < 20; i++) begin
            @(negedge dst_clk);
            if (dst_valid) break;
        end
        total++;
        if (dst_valid !== 1'b1) $display("FAIL bp_valid_rise: got %b, need 1", dst_valid);
        else passed++;
        for (int i = 0; i < 20; i++) begin
            @(negedge dst_clk);
            total++;
            if (dst_valid !== 1'b1 || dst_data !== 8'h3C || src_ready !== 1'b0)
                $display("FAIL bp_hold: valid=%b data=%h ready=%b, need 1 3c 0", dst_valid, dst_data, src_ready);
            else
                passed++;
        end
        drive_dst_ready(1'b1);
        for (int i = 0; i < 40; i++) begin
            @(negedge src_clk);
            if (src_ready) break;
        end
        total++;
        if (src_ready !== 1'b1) $display("FAIL bp_src_return: got %b, need 1", src_ready);
        else passed++;
        total++;
        if (delivered != del0 + 1) $display("FAIL bp_count: got %0d, need %0d", delivered - del0, 1);
        else passed++;
    endtask

    task automatic test_src_wait_toggle;
        bit ok;
        int del0;
        del0 = delivered;
        drive_dst_ready(1'b0);
        src_offer(8'h11, ok);
        total++;
        if (!ok) $display("FAIL wait_accept: got no accept, need accept");
        else passed++;
        for (int i = 0; i < 15; i++) begin
            @(posedge src_clk);
            #1;
            src_valid = 1'($urandom_range(0, 1));
            src_data  = 8'($urandom);
            @(negedge src_clk);
            total++;
            if (src_ready !== 1'b0) $display("FAIL wait_ready: got %b, need 0", src_ready);
            else passed++;
        end
        @(posedge src_clk);
        #1 src_valid = 1'b0;
        drive_dst_ready(1'b1);
        for (int i = 0; i < 40; i++) begin
            @(negedge dst_clk);
            if (delivered != del0) break;
        end
        total++;
        if (delivered != del0 + 1 || dst_data !== 8'h11)
            $display("FAIL wait_data: got %0d words last %h, need 1 word 11", delivered - del0, dst_data);
        else
            passed++;
        for (int i = 0; i < 40; i++) begin
            @(negedge src_clk);
            if (src_ready) break;
        end
    endtask

    task automatic test_back_to_back(input real sh, input real dh);
        int n;
        int guard;
        int del0;
        src_half = sh;
        dst_half = dh;
        repeat (4) @(posedge src_clk);
        drive_dst_ready(1'b1);
        del0 = delivered;
        n = 0;
        guard = 0;
        @(posedge src_clk);
        #1;
        src_data  = 8'h00;
        src_valid = 1'b1;
        while (n < 256 && guard < 20000) begin
            @(negedge src_clk);
            guard++;
            if (src_ready) begin
                @(posedge src_clk);
                n++;
                #1;
                src_data = n[7:0];
                if (n == 256) src_valid = 1'b0;
            end
        end
        src_valid = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge dst_clk);
            if (exp_q.size() == 0 && !dst_valid) break;
        end
        total++;
        if (n != 256) $display("FAIL b2b_accepts: got %0d, need 256", n);
        else passed++;
        total++;
        if (delivered - del0 != 256) $display("FAIL b2b_deliveries: got %0d, need 256", delivered - del0);
        else passed++;
        total++;
        if (exp_q.size() != 0) $display("FAIL b2b_drain: got %0d left, need 0", exp_q.size());
        else passed++;
        total++;
        if (dst_data !== 8'hFF) $display("FAIL b2b_last: got %h, need ff", dst_data);
        else passed++;
    endtask

    task automatic test_mid_reset;
        bit ok;
        int del0;
        src_half = 5.0;
        dst_half = 13.5;
        repeat (4) @(posedge src_clk);
        drive_dst_ready(1'b0);
        src_offer(8'h77, ok);
        total++;
        if (!ok) $display("FAIL rst_accept: got no accept, need accept");
        else passed++;
        repeat (2) @(posedge dst_clk);
        #1;
        src_rst_n = 1'b0;
        dst_rst_n = 1'b0;
        exp_q.delete();
        #2;
        total++;
        if (src_ready !== 1'b1 || dst_valid !== 1'b0 || dst_data !== 8'h00)
            $display("FAIL rst_async: ready=%b valid=%b data=%h, need 1 0 00", src_ready, dst_valid, dst_data);
        else
            passed++;
        repeat (3) @(posedge src_clk);
        @(posedge dst_clk);
        #1 dst_rst_n = 1'b1;
        @(posedge src_clk);
        #1 src_rst_n = 1'b1;
        del0 = delivered;
        drive_dst_ready(1'b1);
        for (int i = 0; i < 20; i++) begin
            @(negedge dst_clk);
            total++;
            if (dst_valid !== 1'b0) $display("FAIL rst_spurious: got valid=%b, need 0", dst_valid);
            else passed++;
        end
        total++;
        if (src_ready !== 1'b1 || delivered != del0)
            $display("FAIL rst_after: ready=%b words=%0d, need 1 0", src_ready, delivered - del0);
        else
            passed++;
    endtask

    task automatic test_random;
        int acc0;
        int del0;
        acc0 = accepted;
        del0 = delivered;
        rnd_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 10000; i++) begin
                    @(posedge src_clk);
                    #1;
                    src_valid = 1'($urandom_range(0, 1));
                    src_data  = 8'($urandom);
                end
                @(posedge src_clk);
                #1 src_valid = 1'b0;
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge dst_clk);
                    #1 dst_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        drive_dst_ready(1'b1);
        for (int i = 0; i < 200; i++) begin
            @(negedge dst_clk);
            if (exp_q.size() == 0 && !dst_valid && src_ready) break;
        end
        total++;
        if (exp_q.size() != 0) $display("FAIL rnd_drain: got %0d left, need 0", exp_q.size());
        else passed++;
        total++;
        if (accepted - acc0 != delivered - del0)
            $display("FAIL rnd_count: delivered %0d, need %0d", delivered - del0, accepted - acc0);
        else
            passed++;
        total++;
        if (accepted - acc0 < 100) $display("FAIL rnd_traffic: got %0d words, need >=100", accepted - acc0);
        else passed++;
    endtask

    initial begin
        src_rst_n = 1'b0;
        dst_rst_n = 1'b0;
        src_valid = 1'b0;
        src_data  = '0;
        dst_ready = 1'b0;
        fork
            src_monitor();
            dst_monitor();
        join_none
        test_reset();
        test_single();
        test_backpressure();
        test_src_wait_toggle();
        test_back_to_back(5.0, 13.5);
        test_back_to_back(13.5, 5.0);
        test_mid_reset();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/req_ack_cdc.md
REQ_ACK_CDC -- requirements
Module: req_ack_cdc

Interface
REQ-001 Parameter WIDTH, default 8, payload width in bits.
REQ-002 Parameter SYNC_STAGES, default 2, flops per synchronizer chain; legal values are 2 or more.
REQ-003 src_clk  input  1  source-domain clock.
REQ-004 src_rst_n  input  1  source-domain reset: reset src_rst_n, asynchronous, active-low; clock src_clk.
REQ-005 dst_clk  input  1  destination-domain clock, asynchronous to src_clk.
REQ-006 dst_rst_n  input  1  destination-domain reset, asynchronous, active-low.
REQ-007 src_valid  input  1  source offers src_data.
REQ-008 src_ready  output  1  block can accept a word.
REQ-009 src_data  input  WIDTH  source payload.
REQ-010 dst_valid  output  1  dst_data holds a delivered word.
REQ-011 dst_ready  input  1  destination consumes the word.
REQ-012 dst_data  output  WIDTH  delivered payload.
REQ-013 src_busy  output  1  transfer in flight; always equals the inverse of src_ready.

Function
REQ-014 The block uses a 2-phase toggle protocol: a req toggle in src domain and an ack toggle in dst domain; each is synchronized into the opposite domain through SYNC_STAGES flops.
REQ-015 Source FSM states are S_IDLE and S_WAIT; src_ready = 1 only in S_IDLE.
REQ-016 S_IDLE with src_valid=1 at a src_clk edge: the block captures src_data into the src hold register, inverts req_tgl and enters S_WAIT.
REQ-017 In S_WAIT the hold register and req_tgl are frozen; src_valid and src_data are ignored.
REQ-018 In S_WAIT, when the synchronized ack equals req_tgl, the FSM enters S_IDLE at the next src_clk edge.
REQ-019 Nominal src_ready return is SYNC_STAGES+1 src_clk edges after ack_tgl toggles, with +1 edge allowed for metastability resolution.
REQ-020 Destination FSM states are D_IDLE and D_VALID; dst_valid = 1 only in D_VALID.
REQ-021 D_IDLE with synchronized req != ack_tgl: dst_data is loaded from the src hold register and the FSM enters D_VALID at that dst_clk edge.
REQ-022 The hold register is guaranteed stable whenever the dst domain samples it, so it is sampled without a synchronizer; it is the only multi-bit crossing.
REQ-023 Nominal dst_valid rise is SYNC_STAGES+1 dst_clk edges after req_tgl toggles, with +1 edge allowed.
REQ-024 In D_VALID, dst_data and dst_valid hold stable until dst_ready=1.
REQ-025 D_VALID with dst_ready=1 at a dst_clk edge: the block inverts ack_tgl and enters D_IDLE; dst_data retains its last value.
REQ-026 dst_ready while in D_IDLE has no effect.
REQ-027 At most one word is in flight; each accepted word is delivered exactly once, in order, with no loss or duplication.
REQ-028 Minimum round trip per word is 2*(SYNC_STAGES+1) edges across the two domains, plus destination stall time.
REQ-029 A src_valid held high across consecutive transfers is accepted again on the first S_IDLE edge after return, with no idle gap required.

Reset
REQ-030 When src_rst_n is low, the src domain clears to: S_IDLE, req_tgl=0, hold register=0, src ack sync chain=0; src_ready=1 and src_busy=0.
REQ-031 When dst_rst_n is low, the dst domain clears to: D_IDLE, ack_tgl=0, dst_data=0, dst req sync chain=0; dst_valid=0.
REQ-032 Reset assertion is asynchronous; deassertion is synchronized externally to the respective clock.
REQ-033 Both resets are asserted together; the block does not recover from a single-domain reset.
REQ-034 A simultaneous reset mid-transfer discards the word, and the block produces no dst_valid after release.

Verification
REQ-035 Single word, src 100 MHz / dst 37 MHz, dst_ready=1: src_data=0xA5 accepted -> dst_valid rises within 3-4 dst edges with dst_data=0xA5, src_ready returns within 3-4 src edges of the ack toggle.
REQ-036 Backpressure, dst_ready=0 for 20 dst cycles after dst_valid -> dst_valid and dst_data=0x3C held stable, src_ready stays 0, and the word completes once dst_ready=1.
REQ-037 Burst of 256 incrementing words 0x00-0xFF with src_valid held high, under both fast-src and fast-dst clock ratios -> exactly 256 deliveries, in order, no duplicates.
REQ-038 src_valid toggling while in S_WAIT with changing src_data -> delivered word equals the value at the accept edge only.
REQ-039 Both resets asserted two dst cycles after accept -> dst_valid=0, src_ready=1 after release, and no spurious delivery within 20 cycles.
REQ-040 Random dst_ready and src_valid for 10k cycles, plus a scoreboard and assertions (dst_data stable while dst_valid and not dst_ready; src_ready equals the inverse of src_busy) -> zero mismatches.
